// File: rtl/uart_mmio_bridge.sv
// UART endpoint behind the CPU MMIO ports: TX FIFO feeding an 8N1 serializer,
// and an 8N1 deserializer into a single-byte holding register released by uart_consumed.
module uart_mmio_bridge #(
  parameter int CLKS_PER_BIT       = 868,
  parameter int TX_FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_we,
  input  logic [7:0] uart_wdata,
  input  logic       uart_consumed,
  output logic       uart_ready,
  output logic [7:0] uart_rdata,
  output logic       tx,
  input  logic       rx,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int AW    = TX_FIFO_DEPTH_LOG2;
  localparam int PW    = TX_FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << TX_FIFO_DEPTH_LOG2;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID = TW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, cnt, cnt_nxt;
  logic          push, pop, fifo_empty, fifo_full;

  assign cnt        = wr_ptr - rd_ptr;
  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == PW'(DEPTH));
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign push       = uart_we && (!fifo_full || pop);
  assign cnt_nxt    = cnt + PW'(push) - PW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= uart_wdata;
  end

  // ---------------- TX FSM ----------------
  state_t        tx_state, tx_state_nxt;
  logic [TW-1:0] tx_tmr, tx_tmr_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [7:0]    tx_sh, tx_sh_nxt;
  logic          tx_end;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tmr_nxt   = tx_tmr + TW'(1);
    tx_bit_nxt   = tx_bit;
    tx_sh_nxt    = tx_sh;
    pop          = 1'b0;
    tx_end       = (tx_tmr == T_END);
    case (tx_state)
      S_IDLE: begin
        tx_tmr_nxt = '0;
        if (!fifo_empty) begin
          pop          = 1'b1;
          tx_sh_nxt    = mem[rd_ptr[AW-1:0]];
          tx_state_nxt = S_START;
        end
      end
      S_START: if (tx_end) begin
        tx_tmr_nxt   = '0;
        tx_bit_nxt   = '0;
        tx_state_nxt = S_DATA;
      end
      S_DATA: if (tx_end) begin
        tx_tmr_nxt = '0;
        tx_sh_nxt  = {1'b0, tx_sh[7:1]};
        tx_bit_nxt = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_nxt = S_STOP;
      end
      S_STOP: if (tx_end) begin
        tx_tmr_nxt   = '0;
        tx_state_nxt = S_IDLE;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  // Decoded straight from state so reset forces the line high without waiting for a clock.
  assign tx = (tx_state == S_START) ? 1'b0 :
              (tx_state == S_DATA)  ? tx_sh[0] : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_state <= S_IDLE;
      tx_tmr   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_full  <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      tx_state <= tx_state_nxt;
      tx_tmr   <= tx_tmr_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_sh    <= tx_sh_nxt;
      tx_full  <= (cnt_nxt == PW'(DEPTH));
      tx_busy  <= (cnt_nxt != '0) || (tx_state_nxt != S_IDLE);
    end
  end

  // ---------------- RX path ----------------
  logic          rx_m, rx_s, rx_s_d;
  state_t        rx_state, rx_state_nxt;
  logic [TW-1:0] rx_tmr, rx_tmr_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_sh, rx_sh_nxt;
  logic          rx_wait, rx_wait_nxt;
  logic          deliver, ferr_set;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tmr_nxt   = rx_tmr + TW'(1);
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    rx_wait_nxt  = rx_wait;
    deliver      = 1'b0;
    ferr_set     = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_tmr_nxt = '0;
        if (rx_s_d && !rx_s) rx_state_nxt = S_START;
      end
      S_START: if (rx_tmr == T_MID) begin
        rx_tmr_nxt   = '0;
        rx_bit_nxt   = '0;
        rx_state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tmr == T_END) begin
        rx_tmr_nxt = '0;
        rx_sh_nxt  = {rx_s, rx_sh[7:1]};
        rx_bit_nxt = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
      end
      S_STOP: begin
        // After a bad stop bit, hold here until the line returns high so the
        // low stop bit is not mistaken for a new start edge.
        if (rx_wait) begin
          rx_tmr_nxt = rx_tmr;
          if (rx_s) begin
            rx_wait_nxt  = 1'b0;
            rx_state_nxt = S_IDLE;
          end
        end else if (rx_tmr == T_END) begin
          rx_tmr_nxt = '0;
          if (rx_s) begin
            deliver      = 1'b1;
            rx_state_nxt = S_IDLE;
          end else begin
            ferr_set    = 1'b1;
            rx_wait_nxt = 1'b1;
          end
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      rx_s_d       <= 1'b1;
      rx_state     <= S_IDLE;
      rx_tmr       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_wait      <= 1'b0;
      uart_ready   <= 1'b0;
      uart_rdata   <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_s_d   <= rx_s;
      rx_state <= rx_state_nxt;
      rx_tmr   <= rx_tmr_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_sh    <= rx_sh_nxt;
      rx_wait  <= rx_wait_nxt;
      if (deliver && (!uart_ready || uart_consumed)) begin
        uart_rdata <= rx_sh;
        uart_ready <= 1'b1;
      end else if (deliver) begin
        rx_overrun <= 1'b1;
      end else if (uart_consumed) begin
        uart_ready <= 1'b0;
      end
      if (ferr_set) rx_frame_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge at CLKS_PER_BIT=4: TX framing, FIFO fill/drop,
// RX delivery/consume/overrun, glitch and framing error, loopback with mid-frame reset.
module tb_uart_mmio_bridge;
  localparam int CPB  = 4;
  localparam int LOGN = 8192;

  logic       clk = 1'b0, rst = 1'b0;
  logic       uart_we = 1'b0, uart_consumed = 1'b0;
  logic [7:0] uart_wdata = 8'h00;
  logic       rx_drv = 1'b1, loop_en = 1'b0;
  logic       rx;
  logic       uart_ready, tx, tx_full, tx_busy, rx_overrun, rx_frame_err;
  logic [7:0] uart_rdata;

  assign rx = loop_en ? tx : rx_drv;

  uart_mmio_bridge #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .uart_we(uart_we), .uart_wdata(uart_wdata),
    .uart_consumed(uart_consumed), .uart_ready(uart_ready), .uart_rdata(uart_rdata),
    .tx(tx), .rx(rx), .tx_full(tx_full), .tx_busy(tx_busy),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  // tx line recorded once per cycle for offline frame decoding
  logic tx_log [LOGN];
  int   ncyc = 0;
  always @(negedge clk) begin
    if (ncyc < LOGN) tx_log[ncyc] <= tx;
    ncyc <= ncyc + 1;
  end

  int checks = 0, passes = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic consume();
    uart_consumed = 1'b1;
    @(negedge clk);
    uart_consumed = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    int n = 0;
    while (!uart_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [44:0] got45, exp45;
  logic [7:0]  pat, b;
  logic        busy_mid;
  int          base, idx, s, prev, zeros;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", uart_ready, 0);
    chk("rst_rdata", uart_rdata, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_ferr", rx_frame_err, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5: pop cycle, start, LSB-first data, stop
    pat = 8'hA5;
    exp45 = '1;
    exp45[43:40] = 4'h0;
    for (int bi = 0; bi < 8; bi++)
      for (int k = 0; k < 4; k++) exp45[39 - 4*bi - k] = pat[bi];
    uart_wdata = pat; uart_we = 1'b1;
    @(negedge clk);
    uart_we = 1'b0;
    for (int i = 0; i < 45; i++) begin
      got45[44 - i] = tx;
      if (i == 1) busy_mid = tx_busy;
      if (i < 44) @(negedge clk);
    end
    chk("a5_wave", got45, exp45);
    chk("a5_busy_mid", busy_mid, 1);
    @(negedge clk);
    chk("a5_busy_done", tx_busy, 0);
    repeat (3) @(negedge clk);

    // 17 back-to-back pushes into a 16-deep FIFO, then one push while full
    base = ncyc;
    for (int k = 0; k < 17; k++) begin
      uart_wdata = 8'(k); uart_we = 1'b1;
      @(negedge clk);
      if (k == 15) chk("full_after_16", tx_full, 0);
      if (k == 16) chk("full_after_17", tx_full, 1);
    end
    uart_wdata = 8'h99;
    @(negedge clk);
    uart_we = 1'b0;
    chk("full_after_drop", tx_full, 1);
    repeat (17*41 + 40) @(negedge clk);
    chk("fifo_drained_busy", tx_busy, 0);
    idx = base; prev = -1;
    for (int k = 0; k < 17; k++) begin
      while (idx < ncyc - 1 && tx_log[idx] == 1'b1) idx++;
      s = idx;
      for (int i = 0; i < 8; i++) b[i] = tx_log[s + 4 + 4*i + 2];
      chk($sformatf("fifo_byte%0d", k), b, 8'(k));
      if (k > 0) chk($sformatf("fifo_gap%0d", k), s - prev, 41);
      prev = s;
      idx = s + 40;
    end
    zeros = 0;
    for (int i = idx; i < ncyc - 1; i++) if (tx_log[i] == 1'b0) zeros++;
    chk("fifo_no_extra", zeros, 0);

    // RX delivery and consume
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    chk("rx3c_ready", uart_ready, 1);
    chk("rx3c_data", uart_rdata, 8'h3C);
    consume();
    chk("rx3c_consumed", uart_ready, 0);
    chk("rx3c_hold", uart_rdata, 8'h3C);
    consume();
    chk("consume_idle", uart_ready, 0);

    // delivery coinciding with consume replaces the byte without overrun
    send_frame(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    chk("rx11_data", uart_rdata, 8'h11);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    consume();
    repeat (2) @(negedge clk);
    chk("rx22_data", uart_rdata, 8'h22);
    chk("rx22_ready", uart_ready, 1);
    chk("rx22_no_ovr", rx_overrun, 0);

    // unconsumed byte: new frame dropped, overrun set
    send_frame(8'h33, 1'b1);
    repeat (4) @(negedge clk);
    chk("ovr_set", rx_overrun, 1);
    chk("ovr_data", uart_rdata, 8'h22);
    chk("ovr_ready", uart_ready, 1);
    consume();

    // one-cycle glitch is ignored
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_ready", uart_ready, 0);
    send_frame(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    chk("rx44_data", uart_rdata, 8'h44);

    // framing error: byte discarded, flag sticky, receiver recovers
    send_frame(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    chk("ferr_set", rx_frame_err, 1);
    chk("ferr_ready", uart_ready, 1);
    chk("ferr_data", uart_rdata, 8'h44);
    consume();
    send_frame(8'h66, 1'b1);
    repeat (4) @(negedge clk);
    chk("rx66_data", uart_rdata, 8'h66);
    chk("rx66_ready", uart_ready, 1);
    consume();

    // loopback, reset in the middle of the second frame
    loop_en = 1'b1;
    uart_wdata = 8'h5A; uart_we = 1'b1;
    @(negedge clk);
    uart_wdata = 8'hC3;
    @(negedge clk);
    uart_we = 1'b0;
    wait_ready(200);
    chk("lb5a_ready", uart_ready, 1);
    chk("lb5a_data", uart_rdata, 8'h5A);
    repeat (12) @(negedge clk);
    chk("lbc3_busy", tx_busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", uart_ready, 0);
    chk("mid_rst_rdata", uart_rdata, 0);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_full", tx_full, 0);
    chk("mid_rst_ovr", rx_overrun, 0);
    chk("mid_rst_ferr", rx_frame_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    uart_wdata = 8'h7E; uart_we = 1'b1;
    @(negedge clk);
    uart_we = 1'b0;
    wait_ready(200);
    chk("lb7e_ready", uart_ready, 1);
    chk("lb7e_data", uart_rdata, 8'h7E);
    chk("lb7e_ferr", rx_frame_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
